// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter sharing one NoC injection link among N packetizers, with final-output counting.
// Optional build macro ADDER_PRIORITY_EN gives the adder packetizer absolute priority in arbitration.
module noc_inject_arbiter #(
  parameter int          N          = 4,
  parameter int          PWIDTH     = 47,
  parameter int          SRC_LSB    = 40,
  parameter logic [2:0]  ADDER_SRC  = 3'b100,
  parameter int          NUM_FINAL  = 25,
  parameter int          ADDER_PORT = N - 1,
  localparam int         GW         = $clog2(N),
  localparam int         CW         = $clog2(NUM_FINAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*PWIDTH-1:0]   req_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PWIDTH-1:0]     out_data,
  output logic [GW-1:0]         grant_id,
  output logic [CW-1:0]         final_count,
  output logic                  done
);

`ifdef ADDER_PRIORITY_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [GW-1:0]     last_q;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     win_idx;
  logic              win_vld;
  logic              upd_last;
  logic [PWIDTH-1:0] req_pkt [N];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(NUM_FINAL)) ? c : c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) req_pkt[i] = req_data[i*PWIDTH +: PWIDTH];
  end

  // Search starts just past the last winner, so last itself is examined at the very end.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    upd_last = 1'b1;
    for (int k = 1; k <= N; k++) begin
      cand = GW'((int'(last_q) + k) % N);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    if (PRIO_EN && req_valid[ADDER_PORT]) begin
      win_vld  = 1'b1;
      win_idx  = GW'(ADDER_PORT);
      upd_last = 1'b0;
    end
  end

  assign req_ready = (state == IDLE && win_vld) ? (N'(1) << win_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      grant_id    <= '0;
      last_q      <= GW'(N - 1);
      final_count <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            out_data  <= req_pkt[win_idx];
            grant_id  <= win_idx;
            out_valid <= 1'b1;
            state     <= SEND;
            if (upd_last) last_q <= win_idx;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            if (out_data[SRC_LSB+2:SRC_LSB] == ADDER_SRC) begin
              final_count <= sat_inc(final_count);
              if (final_count == CW'(NUM_FINAL - 1)) done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: per-cycle reference model with a packet scoreboard,
// table-driven vectors for arbitration order, and hand sequences for backpressure, reset and done.
module tb_noc_inject_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [187:0] req_data;
  logic         out_valid;
  logic         out_ready;
  logic [46:0]  out_data;
  logic [1:0]   grant_id;
  logic [4:0]   final_count;
  logic         done;

  logic [46:0]  pd [4];
  assign req_data = {pd[3], pd[2], pd[1], pd[0]};

  noc_inject_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .grant_id(grant_id), .final_count(final_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [46:0] data; int gid; } exp_t;
  typedef struct { logic [3:0] v; logic rdy; logic [3:0] rr; logic ov; int gid; } vec_t;

  exp_t q[$];
  vec_t tv[$];
  int checks = 0;
  int errors = 0;
  int m_last, m_count, p1_cnt;
  bit m_send, m_done, regen;
  logic [3:0] acc;
  logic [46:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [46:0] new_pkt(input int p);
    logic [2:0] s;
    s = (p == 3) ? 3'b100 : 3'b001;
    return {4'($urandom), s, $urandom, 8'($urandom)};
  endfunction

  task automatic winner(output bit found, output int w);
    found = 0;
    w = 0;
`ifdef ADDER_PRIORITY_EN
    if (req_valid[3]) begin
      found = 1;
      w = 3;
      return;
    end
`endif
    for (int k = 1; k <= 4; k++) begin
      if (!found && req_valid[(m_last + k) % 4]) begin
        found = 1;
        w = (m_last + k) % 4;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 3; m_count = 0; m_send = 0; m_done = 0; p1_cnt = 0;
  endtask

  // Compare DUT against the model state, then advance the model across the coming edge.
  task automatic sample();
    bit found;
    int w;
    exp_t e;
    logic [3:0] exp_rr;
    @(negedge clk);
    winner(found, w);
    exp_rr = (!m_send && found) ? 4'(1 << w) : 4'b0000;
    chk("out_valid", out_valid, m_send);
    chk("req_ready", req_ready, exp_rr);
    chk("final_count", final_count, m_count);
    chk("done", done, m_done);
    acc = '0;
    if (m_send) begin
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=handshake required=none");
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("grant_id", grant_id, e.gid);
          if (e.data[42:40] == 3'b100 && m_count < 25) begin
            m_count++;
            if (m_count == 25) m_done = 1;
          end
          if (e.gid == 1) p1_cnt++;
        end
        m_send = 0;
      end
    end else if (found) begin
      q.push_back('{pd[w], w});
`ifdef ADDER_PRIORITY_EN
      if (w != 3) m_last = w;
`else
      m_last = w;
`endif
      m_send = 1;
      acc[w] = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (regen)
      for (int p = 0; p < 4; p++) if (acc[p]) pd[p] = new_pkt(p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < tv.size(); i++) begin
      req_valid = tv[i].v;
      out_ready = tv[i].rdy;
      sample();
      chk($sformatf("vec%0d_req_ready", i), req_ready, tv[i].rr);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tv[i].ov);
      if (tv[i].gid >= 0) chk($sformatf("vec%0d_grant", i), grant_id, tv[i].gid);
      advance();
    end
    tv.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; regen = 0;
    for (int p = 0; p < 4; p++) pd[p] = new_pkt(p);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 47'h0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_final_count", final_count, 5'd0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;

`ifndef ADDER_PRIORITY_EN
    // Single requester: accepted every other cycle, data unchanged.
    pd[0] = 47'h4_0000_0000_12;
    for (int i = 0; i < 3; i++) begin
      tv.push_back('{4'b0001, 1'b1, 4'b0001, 1'b0, -1});
      tv.push_back('{4'b0001, 1'b1, 4'b0000, 1'b1, 0});
    end
    run_table();
    chk("single_out_data_last", out_data, 47'h4_0000_0000_12);

    // Fairness: all four requesting from reset yields 0,1,2,3,0,1,2,3.
    do_reset();
    regen = 1;
    for (int i = 0; i < 8; i++) begin
      tv.push_back('{4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b0, -1});
      tv.push_back('{4'b1111, 1'b1, 4'b0000, 1'b1, i % 4});
    end
    run_table();
`else
    // Adder port wins every arbitration while it requests; others rotate from 0 otherwise.
    do_reset();
    regen = 1;
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i % 2 == 1) chk("prio_grant", grant_id, 2'd3);
      advance();
    end
    req_valid = 4'b0111;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (i % 2 == 1) chk("rr_rest_grant", grant_id, (i / 2) % 3);
      advance();
    end
`endif

    // Backpressure: packet held for five cycles, released when out_ready rises.
    req_valid = 4'b0000; out_ready = 1'b1;
    sample(); advance();
    sample(); advance();
    req_valid = 4'b0001; out_ready = 1'b0;
    sample(); advance();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_data_stable", out_data, held);
      chk("bp_req_ready", req_ready, 4'b0000);
      advance();
    end
    out_ready = 1'b1;
    sample(); advance();
    chk("bp_released", out_valid, 1'b0);

    // Asynchronous reset while a packet is held.
    req_valid = 4'b0100; out_ready = 1'b0;
    sample(); advance();
    chk("pre_reset_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_final_count", final_count, 5'd0);
    chk("async_done", done, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    req_valid = 4'b1111; out_ready = 1'b1;
    sample();
`ifdef ADDER_PRIORITY_EN
    chk("post_reset_first", req_ready, 4'b1000);
`else
    chk("post_reset_first", req_ready, 4'b0001);
`endif
    advance();

    // Done: 25 adder packets from port 3 interleaved with 10 from port 1.
    req_valid = 4'b1010;
    for (int i = 0; i < 400; i++) begin
      if (p1_cnt >= 10) req_valid[1] = 1'b0;
      if (m_count == 25 && !m_send) break;
      sample(); advance();
    end
    if (m_count != 25) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d required=25", m_count);
    end
    chk("done_count", final_count, 5'd25);
    chk("done_flag", done, 1'b1);
    req_valid = 4'b1000;
    sample(); advance();
    sample(); advance();
    chk("extra_count_hold", final_count, 5'd25);
    chk("extra_done_hold", done, 1'b1);
    chk("extra_forwarded", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Round-robin arbiter that shares one NoC router injection link among N packetizers: the PE partial-sum packetizers and the adder final-output packetizer.
- Forwards 47-bit packets unchanged, one at a time, through a single-entry output register.
- Counts final-output packets, identified by the adder source address, and raises a sticky done flag once the full layer result has been injected.
- Sits between the packetizer bank and the router local input port.

Parameters:
- N, 4, number of requesting packetizers; minimum 2.
- PWIDTH, 47, packet width in bits.
- SRC_LSB, 40, LSB of the 3-bit source-address field; the field is packet[SRC_LSB+2:SRC_LSB].
- ADDER_SRC, 3'b100, source address carried by adder final-output packets.
- NUM_FINAL, 25, number of final outputs per layer.
- ADDER_PORT, N-1, requester index wired to the adder packetizer.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N  per-requester packet valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_data  in  N*PWIDTH  requester i occupies bits [i*PWIDTH +: PWIDTH].
- out_valid  out  1  packet valid toward the router.
- out_ready  in  1  router accept.
- out_data  out  PWIDTH  registered packet.
- grant_id  out  $clog2(N)  index of the requester whose packet is in out_data.
- final_count  out  $clog2(NUM_FINAL+1)  final-output packets injected so far.
- done  out  1  sticky; set when final_count reaches NUM_FINAL.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, grant_id=0, final_count=0, done=0.
  - RR pointer last=N-1, so requester 0 has first priority.
  - A reset mid-SEND drops the held packet; the sending requester already completed its handshake.
- FSM states:
  - IDLE: req_ready is combinational and equals the one-hot of the RR winner among req_valid; it is 0 when no request is valid.
    - On any valid request: out_data<=req_data[winner], grant_id<=winner, last<=winner, out_valid<=1, go to SEND.
    - No request: stay in IDLE.
  - SEND: req_ready=0 and out_data is held stable.
    - When out_valid&&out_ready: out_valid<=0, go to IDLE.
    - When out_ready=0: stay in SEND indefinitely; no timeout.
- RR winner: first i with req_valid[i]=1, searching from last+1 upward and wrapping modulo N.
  - last itself is checked last, so a lone requester wins every arbitration.
- Timing:
  - Latency: request accepted at edge k; out_valid=1 after edge k.
  - Throughput: at most one packet per 2 cycles; IDLE and SEND always alternate.
- Packet handling:
  - Packets pass bit-exact; no field is rewritten.
  - Requesters must hold req_data stable while req_valid=1 and req_ready=0.
- Final-output counting: on an output handshake with out_data[SRC_LSB+2:SRC_LSB]==ADDER_SRC:
  - final_count increments, saturating at NUM_FINAL.
  - done<=1 in the same edge that final_count reaches NUM_FINAL.
  - Adder packets beyond NUM_FINAL are still forwarded; count and done hold.
  - done clears only on reset.
- Simultaneous events: a request that appears on the same edge as the SEND handshake is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: ADDER_PRIORITY_EN.
- Defined: in IDLE, if req_valid[ADDER_PORT]=1, ADDER_PORT wins regardless of the RR pointer, and last is not updated. Otherwise, RR runs among the remaining requesters exactly as above.
- Not defined: pure round-robin over all N requesters; ADDER_PORT has no special treatment.

Test Plan:
- Reset release, single requester: req_valid=4'b0001, req_data[0]=47'h4_0000_0000_12, out_ready=1. Required: req_ready=4'b0001 in the IDLE cycle; out_data=47'h4_0000_0000_12 and grant_id=0 one cycle later; then another packet every 2 cycles.
- Fairness: all four req_valid held at 1 for 16 cycles with out_ready=1. Required: grant order 0,1,2,3,0,1,2,3, with 8 packets out.
- Backpressure: out_ready=0 for 5 cycles while in SEND. Required: out_valid=1 and out_data constant throughout; req_ready=0; handshake on the cycle out_ready rises.
- Done flag, NUM_FINAL=25: inject 25 packets with src=3'b100 on port 3, interleaved with 10 packets with src=3'b001.
  - Required: final_count=25 and done=1 right after the 25th adder handshake.
  - A 26th adder packet is still forwarded; final_count stays 25.
- Asynchronous reset mid-SEND: drop rst_n between clock edges while out_valid=1. Required: out_valid=0, final_count=0, done=0 immediately; the next grant goes to requester 0.
- ADDER_PRIORITY_EN defined: req_valid=4'b1111 continuously. Required: port 3 wins every arbitration. With port 3 deasserted, ports 0,1,2 rotate starting from 0.
